// File: rtl/perceptron_trainer.sv
// Two-input perceptron training engine: predicts from its own sign-magnitude Q15.16
// weights and applies w += LR*(label-pred)*x, tracking epochs and convergence.
module perceptron_trainer #(
    parameter int                          sign       = 1,
    parameter int                          q_m        = 15,
    parameter int                          q_n        = 16,
    parameter logic [sign+q_m+q_n-1:0]     LR         = 32'h0000_4000,
    parameter logic [sign+q_m+q_n-1:0]     INIT_W1    = 32'h0,
    parameter logic [sign+q_m+q_n-1:0]     INIT_W2    = 32'h0,
    parameter logic [sign+q_m+q_n-1:0]     INIT_WB    = 32'h0,
    parameter int                          MAX_EPOCHS = 64,
    parameter int                          EPOCH_W    = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_in,
    input  logic                           sample_valid_in,
    output logic                           sample_ready_out,
    input  logic                           x1_in,
    input  logic                           x2_in,
    input  logic                           label_in,
    input  logic                           last_in,
    output logic                           result_valid_out,
    output logic                           pred_out,
    output logic                           error_out,
    output logic [sign+q_m+q_n-1:0]        w1_out,
    output logic [sign+q_m+q_n-1:0]        w2_out,
    output logic [sign+q_m+q_n-1:0]        wb_out,
    output logic [EPOCH_W-1:0]             epoch_count_out,
    output logic                           converged_out,
    output logic                           done_out
);

    localparam int W = sign + q_m + q_n;

    // Two guard bits above the 32-bit two's-complement range hold a three-term sum.
    localparam logic signed [W+1:0] POS_MAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] NEG_MAX = -POS_MAX;
    localparam logic signed [W+1:0] LR_TC   = {3'b000, LR[W-2:0]};
    localparam logic [EPOCH_W-1:0]  EPOCH_LIMIT = EPOCH_W'(MAX_EPOCHS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREDICT,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic                  x1_q, x2_q, label_q, last_q;
    logic                  err_flag_q;
    logic signed [W:0]     sum_q;
    logic signed [W+1:0]   sum_raw, sum_sat;
    logic                  accept;
    logic                  pred_now, err_now, conv_now;
    logic [EPOCH_W-1:0]    epoch_next;

    function automatic logic signed [W+1:0] to_tc(input logic [W-1:0] w);
        logic signed [W+1:0] mag;
        mag = {3'b000, w[W-2:0]};
        return w[W-1] ? -mag : mag;
    endfunction

    function automatic logic signed [W+1:0] sat(input logic signed [W+1:0] v);
        if (v > POS_MAX) return POS_MAX;
        if (v < NEG_MAX) return NEG_MAX;
        return v;
    endfunction

    // Sign-magnitude weight step of +/-LR; a zero result comes out as +0.
    function automatic logic [W-1:0] sm_step(input logic [W-1:0] w, input logic up);
        logic signed [W+1:0] r;
        logic [W-2:0]        mag;
        r   = sat(up ? to_tc(w) + LR_TC : to_tc(w) - LR_TC);
        mag = r[W+1] ? (W-1)'(-r) : (W-1)'(r);
        return {r[W+1], mag};
    endfunction

    always_comb begin
        sum_raw = to_tc(wb_out);
        if (x1_q) sum_raw = sum_raw + to_tc(w1_out);
        if (x2_q) sum_raw = sum_raw + to_tc(w2_out);
        sum_sat = sat(sum_raw);
    end

    assign pred_now   = (sum_q >= 0);
    assign err_now    = (pred_now != label_q);
    assign conv_now   = !(err_flag_q || err_now);
    assign epoch_next = (&epoch_count_out) ? epoch_count_out : epoch_count_out + 1'b1;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d          = state_q;
        accept           = 1'b0;
        sample_ready_out = (state_q == S_IDLE);
        if (start_in) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sample_valid_in) begin
                        accept  = 1'b1;
                        state_d = S_PREDICT;
                    end
                end
                S_PREDICT: state_d = S_UPDATE;
                S_UPDATE: begin
                    if (last_q && (conv_now || epoch_next == EPOCH_LIMIT))
                        state_d = S_DONE;
                    else
                        state_d = S_IDLE;
                end
                S_DONE:   state_d = S_DONE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1_q             <= 1'b0;
            x2_q             <= 1'b0;
            label_q          <= 1'b0;
            last_q           <= 1'b0;
            sum_q            <= '0;
            err_flag_q       <= 1'b0;
            result_valid_out <= 1'b0;
            pred_out         <= 1'b0;
            error_out        <= 1'b0;
            w1_out           <= INIT_W1;
            w2_out           <= INIT_W2;
            wb_out           <= INIT_WB;
            epoch_count_out  <= '0;
            converged_out    <= 1'b0;
            done_out         <= 1'b0;
        end else if (start_in) begin
            // Restart wins over everything, dropping any sample in flight.
            err_flag_q       <= 1'b0;
            result_valid_out <= 1'b0;
            pred_out         <= 1'b0;
            error_out        <= 1'b0;
            w1_out           <= INIT_W1;
            w2_out           <= INIT_W2;
            wb_out           <= INIT_WB;
            epoch_count_out  <= '0;
            converged_out    <= 1'b0;
            done_out         <= 1'b0;
        end else begin
            result_valid_out <= 1'b0;
            done_out         <= (state_d == S_DONE);

            if (accept) begin
                x1_q    <= x1_in;
                x2_q    <= x2_in;
                label_q <= label_in;
                last_q  <= last_in;
            end

            if (state_q == S_PREDICT)
                sum_q <= (W+1)'(sum_sat);

            if (state_q == S_UPDATE) begin
                result_valid_out <= 1'b1;
                pred_out         <= pred_now;
                error_out        <= err_now;
                if (err_now) begin
                    wb_out <= sm_step(wb_out, label_q);
                    if (x1_q) w1_out <= sm_step(w1_out, label_q);
                    if (x2_q) w2_out <= sm_step(w2_out, label_q);
                end
                if (last_q) begin
                    epoch_count_out <= epoch_next;
                    converged_out   <= conv_now;
                    err_flag_q      <= 1'b0;
                end else if (err_now) begin
                    err_flag_q <= 1'b1;
                end
            end
        end
    end

endmodule
